// File: rtl/rv32m_div_ctrl_if.sv
// Request/response and divider-side signals of the RV32M divide controller.
// slave = the controller, master = the execute stage plus the divider it drives.
interface rv32m_div_ctrl_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic [4:0]      req_tag;
  logic            flush;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic [4:0]      rsp_tag;
  logic            rsp_err;
  logic            div_start;
  logic [XLEN-1:0] div_a;
  logic [XLEN-1:0] div_b;
  logic [XLEN-1:0] div_q;
  logic [XLEN-1:0] div_r;
  logic            div_ok;

  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, req_tag, flush, rsp_ready,
           div_q, div_r, div_ok,
    output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err, div_start, div_a, div_b
  );
  modport master (
    output req_valid, req_op, req_rs1, req_rs2, req_tag, flush, rsp_ready,
           div_q, div_r, div_ok,
    input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err, div_start, div_a, div_b
  );
endinterface

// File: rtl/rv32m_div_ctrl.sv
// Sequencer wrapping an unsigned restoring divider for RV32M DIV/DIVU/REM/REMU:
// sign conversion, special cases, start/ok handshake, sign fix-up, tagged response.
module rv32m_div_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 40
) (
  input logic             clk,
  input logic             reset,
  rv32m_div_ctrl_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, FIXUP, RESP, DRAIN} state_e;

  state_e          state_q;
  logic [1:0]      op_q;
  logic [4:0]      tag_q;
  logic            negq_q, negr_q, busy_seen_q;
  logic [XLEN-1:0] quo_q, rem_q;
  logic [CW-1:0]   cnt_q;
  logic            req_ready_q, rsp_valid_q, rsp_err_q, div_start_q;
  logic [XLEN-1:0] rsp_data_q, div_a_q, div_b_q;
  logic [4:0]      rsp_tag_q;

  // Operand decode on the request bus, used only on the accept edge
  logic            is_signed, rs1_neg, rs2_neg, div0, ovf, special, accept;
  logic [XLEN-1:0] abs_a, abs_b;
  assign is_signed = ~bus.req_op[0];
  assign rs1_neg   = is_signed & bus.req_rs1[XLEN-1];
  assign rs2_neg   = is_signed & bus.req_rs2[XLEN-1];
  assign abs_a     = rs1_neg ? -bus.req_rs1 : bus.req_rs1;
  assign abs_b     = rs2_neg ? -bus.req_rs2 : bus.req_rs2;
  assign div0      = (bus.req_rs2 == '0);
  assign ovf       = is_signed & (bus.req_rs1 == SMIN) & (bus.req_rs2 == '1);
  assign special   = div0 | ovf;
  assign accept    = bus.req_valid & req_ready_q & ~bus.flush;

  logic [XLEN-1:0] sel, fix;
  logic            neg_sel, cnt_done;
  assign sel      = op_q[1] ? rem_q : quo_q;
  assign neg_sel  = op_q[1] ? negr_q : negq_q;
  assign fix      = neg_sel ? -sel : sel;
  assign cnt_done = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      tag_q       <= '0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      busy_seen_q <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      div_start_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      div_a_q     <= '0;
      div_b_q     <= '0;
    end else begin
      div_start_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          op_q        <= bus.req_op;
          tag_q       <= bus.req_tag;
          div_a_q     <= abs_a;
          div_b_q     <= abs_b;
          req_ready_q <= 1'b0;
          cnt_q       <= '0;
          if (special) begin
            // Preload the architectural answer so FIXUP handles both paths alike
            quo_q   <= div0 ? '1 : SMIN;
            rem_q   <= div0 ? bus.req_rs1 : '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            state_q <= FIXUP;
          end else begin
            negq_q      <= rs1_neg ^ rs2_neg;
            negr_q      <= rs1_neg;
            div_start_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          busy_seen_q <= 1'b0;
          state_q     <= bus.flush ? DRAIN : WAIT_BUSY;
        end
        WAIT_BUSY, WAIT_DONE: begin
          if (bus.flush) begin
            busy_seen_q <= (state_q == WAIT_DONE) | ~bus.div_ok;
            cnt_q       <= cnt_q + CW'(1);
            state_q     <= DRAIN;
          end else if (state_q == WAIT_BUSY && !bus.div_ok) begin
            cnt_q   <= cnt_q + CW'(1);
            state_q <= WAIT_DONE;
          end else if (state_q == WAIT_DONE && bus.div_ok) begin
            quo_q   <= bus.div_q;
            rem_q   <= bus.div_r;
            state_q <= FIXUP;
          end else if (cnt_done) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
            rsp_tag_q   <= tag_q;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        FIXUP: begin
          if (bus.flush) begin
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            rsp_data_q  <= fix;
            rsp_tag_q   <= tag_q;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: if (bus.flush || bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        DRAIN: begin
          // Only an ok seen after the divider went busy marks the end of the killed op
          if ((busy_seen_q && bus.div_ok) || cnt_done) begin
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            if (!bus.div_ok) busy_seen_q <= 1'b1;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_tag   = rsp_tag_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.div_start = div_start_q;
  assign bus.div_a     = div_a_q;
  assign bus.div_b     = div_b_q;
endmodule

// File: tb/tb_rv32m_div_ctrl.sv
// Bench for rv32m_div_ctrl: 32-iteration divider model, transaction-level reference
// model checked every cycle, plus directed vectors with literal expectations.
module tb_rv32m_div_ctrl;
  localparam int XLEN = 32, TIMEOUT = 40, DIV_LAT = 32;
  localparam logic [31:0] SMIN = 32'h8000_0000;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;

  rv32m_div_ctrl_if #(.XLEN(XLEN)) bus();
  rv32m_div_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int n_chk = 0, n_err = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Divider: the start edge does iteration 1, ok returns with iteration 32
  logic hang = 1'b0, dm_ok;
  int dm_cnt;
  logic [31:0] dm_a, dm_b, dm_q, dm_r;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      dm_ok <= 1'b1; dm_cnt <= 0; dm_a <= '0; dm_b <= '0; dm_q <= '0; dm_r <= '0;
    end else if (bus.div_start) begin
      dm_ok <= 1'b0; dm_cnt <= DIV_LAT - 1; dm_a <= bus.div_a; dm_b <= bus.div_b;
    end else if (dm_cnt != 0 && !hang) begin
      dm_cnt <= dm_cnt - 1;
      if (dm_cnt == 1) begin
        dm_ok <= 1'b1;
        dm_q  <= (dm_b == 0) ? '1 : dm_a / dm_b;
        dm_r  <= (dm_b == 0) ? dm_a : dm_a % dm_b;
      end
    end
  end
  assign bus.div_ok = dm_ok;
  assign bus.div_q  = dm_q;
  assign bus.div_r  = dm_r;

  int n_starts = 0;
  always @(posedge clk) if (reset && bus.div_start) n_starts++;

  // Architectural RV32M results
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == SMIN && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : SMIN;
    case (op)
      OP_DIV:  return $signed(a) / $signed(b);
      OP_REM:  return $signed(a) % $signed(b);
      OP_DIVU: return a / b;
      default: return a % b;
    endcase
  endfunction
  function automatic logic is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (!op[0] && a == SMIN && b == 32'hFFFF_FFFF);
  endfunction
  function automatic logic [31:0] mag(input logic [1:0] op, input logic [31:0] x);
    return (!op[0] && x[31]) ? 32'h0 - x : x;
  endfunction

  // Transaction model: one op in flight, response due m_lat edges after accept
  typedef enum {M_IDLE, M_BUSY, M_RESP, M_DRAIN} mmode_e;
  mmode_e m_mode;
  int m_k, m_lat;
  logic m_special, m_err, m_started;
  logic [31:0] m_data, m_a, m_b;
  logic [4:0] m_tag;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode <= M_IDLE; m_k <= 0; m_lat <= 0; m_special <= 1'b0; m_err <= 1'b0;
      m_started <= 1'b0; m_data <= '0; m_a <= '0; m_b <= '0; m_tag <= '0;
    end else begin
      case (m_mode)
        M_IDLE: if (bus.req_valid && !bus.flush) begin
          m_special <= is_special(bus.req_op, bus.req_rs1, bus.req_rs2);
          m_err     <= !is_special(bus.req_op, bus.req_rs1, bus.req_rs2) && hang;
          // special: one FIXUP cycle; normal: issue + busy detect + divider + fixup; hung: full wait budget
          m_lat  <= is_special(bus.req_op, bus.req_rs1, bus.req_rs2) ? 1 : (hang ? TIMEOUT + 1 : DIV_LAT + 2);
          m_data <= (!is_special(bus.req_op, bus.req_rs1, bus.req_rs2) && hang) ? 32'h0
                    : ref_result(bus.req_op, bus.req_rs1, bus.req_rs2);
          m_a <= mag(bus.req_op, bus.req_rs1);
          m_b <= mag(bus.req_op, bus.req_rs2);
          m_tag <= bus.req_tag; m_k <= 0; m_started <= 1'b0; m_mode <= M_BUSY;
        end
        M_BUSY: begin
          if (!dm_ok) m_started <= 1'b1;
          if (bus.flush) m_mode <= (!m_err && m_k == m_lat - 1) ? M_IDLE : M_DRAIN;
          else if (m_k + 1 == m_lat) m_mode <= M_RESP;
          m_k <= m_k + 1;
        end
        M_RESP: if (bus.flush || bus.rsp_ready) m_mode <= M_IDLE;
        M_DRAIN: begin
          if (m_started && dm_ok) m_mode <= M_IDLE;
          else if (!dm_ok) m_started <= 1'b1;
        end
        default: m_mode <= M_IDLE;
      endcase
    end
  end

  logic cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en && reset) begin
      check("req_ready", {31'b0, bus.req_ready}, {31'b0, m_mode == M_IDLE});
      check("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, m_mode == M_RESP});
      check("div_start", {31'b0, bus.div_start}, {31'b0, m_mode == M_BUSY && m_k == 0 && !m_special});
      if (m_mode == M_RESP) begin
        check("rsp_data", bus.rsp_data, m_data);
        check("rsp_tag", {27'b0, bus.rsp_tag}, {27'b0, m_tag});
        check("rsp_err", {31'b0, bus.rsp_err}, {31'b0, m_err});
      end
      if (m_mode != M_IDLE && !m_special) begin
        check("div_a", bus.div_a, m_a);
        check("div_b", bus.div_b, m_b);
      end
    end
  end

  task automatic check_reset_state();
    check("rst req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst rsp_data", bus.rsp_data, 32'd0);
    check("rst rsp_tag", {27'b0, bus.rsp_tag}, 32'd0);
    check("rst rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    check("rst div_start", {31'b0, bus.div_start}, 32'd0);
    check("rst div_a", bus.div_a, 32'd0);
    check("rst div_b", bus.div_b, 32'd0);
  endtask

  logic [31:0] last_da, last_db;
  // Issue one op and wait for its response. Latency counts the accept edge up to
  // the edge that first samples rsp_valid high.
  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp_data, input int exp_lat, input int exp_starts);
    int j, s0;
    s0 = n_starts;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_rs1 = a; bus.req_rs2 = b; bus.req_tag = tag;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    last_da = bus.div_a; last_db = bus.div_b;
    j = 0;
    while (!bus.rsp_valid && j < 100) begin
      @(negedge clk);
      j++;
    end
    if (j >= 100) begin
      n_chk++; n_err++;
      $display("FAIL %s no response: waited %0d cycles, expected latency %0d", name, j, exp_lat);
    end else begin
      check({name, " data"}, bus.rsp_data, exp_data);
      check({name, " tag"}, {27'b0, bus.rsp_tag}, {27'b0, tag});
      check({name, " latency"}, j + 1, exp_lat);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({name, " starts"}, n_starts - s0, exp_starts);
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); check_reset_state();
    reset = 1'b1;
  endtask

  int j, s0, vcnt;
  initial begin
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_tag = '0;
    bus.flush = 1'b0; bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state();
    reset = 1'b1;
    cmp_en = 1'b1;

    check("model DIV -7/2", ref_result(OP_DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("model REM -7/2", ref_result(OP_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("model REMU", ref_result(OP_REMU, 32'hFFFF_FFF9, 32'd2), 32'd1);
    check("model DIV ovf", ref_result(OP_DIV, SMIN, 32'hFFFF_FFFF), SMIN);
    check("model REM /0", ref_result(OP_REM, 32'd100, 32'd0), 32'd100);

    do_op("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 35, 1);
    check("DIV -7/2 div_a", last_da, 32'd7);
    check("DIV -7/2 div_b", last_db, 32'd2);
    do_op("REM -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 35, 1);
    do_op("REMU", OP_REMU, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'd1, 35, 1);
    do_op("DIVU /0", OP_DIVU, 32'd100, 32'd0, 5'd8, 32'hFFFF_FFFF, 2, 0);
    do_op("REM /0", OP_REM, 32'd100, 32'd0, 5'd9, 32'd100, 2, 0);
    do_op("DIV ovf", OP_DIV, SMIN, 32'hFFFF_FFFF, 5'd10, SMIN, 2, 0);
    do_op("REM ovf", OP_REM, SMIN, 32'hFFFF_FFFF, 5'd11, 32'd0, 2, 0);
    do_op("DIVU 1000/7", OP_DIVU, 32'd1000, 32'd7, 5'd12, 32'd142, 35, 1);
    do_op("REMU 1000/7", OP_REMU, 32'd1000, 32'd7, 5'd13, 32'd6, 35, 1);
    do_op("DIV 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFD, 35, 1);
    do_op("DIV min/2", OP_DIV, SMIN, 32'd2, 5'd31, 32'hC000_0000, 35, 1);
    do_op("REM -8/-3", OP_REM, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFFE, 35, 1);

    // Backpressure: response held 10 cycles while a competing request is ignored
    s0 = n_starts;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = OP_DIVU; bus.req_rs1 = 32'd50; bus.req_rs2 = 32'd5; bus.req_tag = 5'd20;
    @(posedge clk); @(negedge clk);
    bus.req_rs1 = 32'd77; bus.req_rs2 = 32'd3; bus.req_tag = 5'd21;
    j = 0;
    while (!bus.rsp_valid && j < 100) begin @(negedge clk); j++; end
    repeat (10) @(negedge clk);
    check("hold data", bus.rsp_data, 32'd10);
    check("hold tag", {27'b0, bus.rsp_tag}, 32'd20);
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("hold starts", n_starts - s0, 32'd1);

    // flush in WAIT: drain until the divider reports ok, never respond
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = OP_DIV; bus.req_rs1 = 32'd100; bus.req_rs2 = 32'd3; bus.req_tag = 5'd2;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    j = 0; vcnt = 0;
    while (!bus.req_ready && j < 100) begin
      if (bus.rsp_valid) vcnt++;
      @(negedge clk); j++;
    end
    check("drain ends", {31'b0, bus.req_ready}, 32'd1);
    check("drain div_ok", {31'b0, dm_ok}, 32'd1);
    check("drain no rsp", vcnt, 32'd0);
    do_op("after drain", OP_DIVU, 32'd81, 32'd9, 5'd3, 32'd9, 35, 1);

    // flush while the response is pending, even with rsp_ready high
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = OP_DIVU; bus.req_rs1 = 32'd9; bus.req_rs2 = 32'd0; bus.req_tag = 5'd4;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    bus.flush = 1'b1; bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0; bus.rsp_ready = 1'b0;
    check("flush resp", {31'b0, bus.rsp_valid}, 32'd0);

    // Hung divider forces an error response after the wait budget
    hang = 1'b1;
    do_op("timeout", OP_DIVU, 32'd50, 32'd5, 5'd17, 32'd0, TIMEOUT + 2, 1);
    pulse_reset();
    hang = 1'b0;

    // Reset in the middle of an operation
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = OP_REMU; bus.req_rs1 = 32'd99; bus.req_rs2 = 32'd10; bus.req_tag = 5'd15;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (10) @(negedge clk);
    pulse_reset();
    do_op("after reset", OP_REMU, 32'd99, 32'd10, 5'd16, 32'd9, 35, 1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rv32m_div_ctrl.md
Name: rv32m_div_ctrl

Overview:
- Initiator/sequencer for the team's 32-iteration unsigned restoring divider.
- Accepts RV32M DIV/DIVU/REM/REMU requests from the execute stage and performs the sign conversion.
- Resolves the RISC-V special cases (divide-by-zero, signed overflow) without using the divider.
- Drives the divider's start/ok handshake, applies the sign fix-up and returns a tagged result with a valid/ready handshake.

Parameters:
- XLEN, 32, operand and result width.
- TIMEOUT, 40, maximum cycles spent waiting on the divider before an error response is forced.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
- req_rs1  in  XLEN  dividend
- req_rs2  in  XLEN  divisor
- req_tag  in  5  destination register tag, passed through unchanged
- flush  in  1  kill the in-flight operation
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes the result
- rsp_data  out  XLEN  result
- rsp_tag  out  5  tag of the result
- rsp_err  out  1  timeout occurred; rsp_data is then 0
- div_start  out  1  one-cycle start pulse to the divider
- div_a  out  XLEN  unsigned dividend to the divider
- div_b  out  XLEN  unsigned divisor to the divider
- div_q  in  XLEN  divider quotient
- div_r  in  XLEN  divider remainder
- div_ok  in  1  divider idle/done (low while iterating)

Behaviour:
- Reset (async, reset=0): state IDLE.
  - req_ready=1.
  - rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_err=0.
  - div_start=0, div_a=0, div_b=0.
  - Timeout counter cleared.
- Reset mid-operation aborts everything; the divider shares the same reset.
- A request is accepted when req_valid & req_ready at a rising edge. At that edge the controller latches op, tag, the sign flags and the operands.
- Signed ops (DIV, REM):
  - div_a = |rs1|, div_b = |rs2| (two's complement; |0x80000000| = 0x80000000 unsigned).
  - neg_q = sign(rs1) XOR sign(rs2).
  - neg_r = sign(rs1).
- Unsigned ops: operands pass unchanged; neg_q = neg_r = 0.
- Special cases are detected at acceptance; the next state is FIXUP and the divider is not started:
  - rs2 == 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - DIV/REM with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- State transitions:
  - IDLE -> ISSUE on a normal accept; IDLE -> FIXUP on a special-case accept.
  - ISSUE: div_start=1 for exactly one cycle -> WAIT_BUSY.
  - WAIT_BUSY: wait for div_ok=0 -> WAIT_DONE. This guards against sampling a stale ok=1.
  - WAIT_DONE: wait for div_ok=1; capture div_q/div_r -> FIXUP.
  - FIXUP:
    - Select quotient (DIV/DIVU) or remainder (REM/REMU).
    - Negate if the matching neg flag is set.
    - Register rsp_data and rsp_tag; -> RESP.
  - RESP: rsp_valid=1. rsp_data, rsp_tag and rsp_err are held stable until rsp_ready. On rsp_valid & rsp_ready -> IDLE, and rsp_valid drops the next cycle.
- Timeout:
  - The counter runs in WAIT_BUSY/WAIT_DONE and clears on entry to ISSUE.
  - When it reaches TIMEOUT: -> RESP with rsp_err=1, rsp_data=0.
- div_a and div_b stay stable from ISSUE until the controller returns to IDLE.
- Latency (accept edge to rsp_valid high):
  - Normal ops with the 32-iteration divider: 35 cycles.
  - Special cases: 2 cycles.
- flush:
  - In IDLE, FIXUP or RESP: -> IDLE next edge; rsp_valid is deasserted and no response is issued.
  - In ISSUE, WAIT_BUSY or WAIT_DONE: -> DRAIN. DRAIN waits until the divider has started and then returns div_ok=1 (or timeout), discards the result and goes to IDLE.
  - req_ready is held 0 throughout DRAIN.
- flush and rsp_ready in the same RESP cycle: flush wins; the handshake is treated as not completed.
- req_valid while not in IDLE: ignored (req_ready=0). No queuing; the controller holds one operation at a time.

Test Plan:
- DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> div_a=7, div_b=2, one div_start pulse; rsp_data=0xFFFFFFFD (-3), tag echoed, rsp_valid 35 cycles after accept.
- REM rs1=-7, rs2=2 -> rsp_data=0xFFFFFFFF (-1); REMU rs1=0xFFFFFFF9, rs2=2 -> rsp_data=1.
- DIVU rs1=100, rs2=0 -> no div_start, rsp_data=0xFFFFFFFF within 2 cycles; REM rs1=100, rs2=0 -> rsp_data=100.
- DIV 0x80000000 / 0xFFFFFFFF -> rsp_data=0x80000000; REM on the same operands -> 0; no div_start.
- Normal op with rsp_ready held low for 10 cycles -> rsp_valid, rsp_data and rsp_tag stable the whole time; new req_valid ignored until after the handshake.
- flush 5 cycles after issue -> DRAIN, no rsp_valid, req_ready returns 1 only after div_ok=1. Separately, a divider model that never raises ok -> rsp_err=1, rsp_data=0 after TIMEOUT=40 wait cycles.
